// File: rtl/sync_tx_scheduler.sv
// sync_tx_scheduler: round-robin arbiter that sends one word at a time through a bus-enable/data CDC crossing
module sync_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ctrl_en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BUS_WIDTH-1:0]         unsync_bus,
    output logic                         bus_enable,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         xfer_done
);
    localparam int ID_W = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   timer_q, timer_d;
    logic [BUS_WIDTH-1:0]   bus_q, bus_d;
    logic                   en_q, en_d;
    logic [ID_W-1:0]        gid_q, gid_d, rr_q, rr_d, sel, idx;
    logic                   found, hs;
    logic [BUS_WIDTH-1:0]   words [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
    end
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
    assign hs         = (state_q == IDLE) && ctrl_en && found;
    assign req_ready  = hs ? (NUM_REQ'(1) << sel) : '0;
    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign grant_id   = gid_q;
    assign busy       = state_q != IDLE;
    assign xfer_done  = (state_q == GAP) && (timer_q == '0);
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bus_d   = bus_q;
        en_d    = en_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        if (hs) begin
            bus_d   = words[sel];
            gid_d   = sel;
            rr_d    = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            en_d    = 1'b1;
            timer_d = CNT_WIDTH'(HOLD_CYCLES - 1);
            state_d = ASSERT;
        end else if (state_q == ASSERT) begin
            en_d    = timer_q != '0;
            timer_d = (timer_q == '0) ? CNT_WIDTH'(GAP_CYCLES - 1) : timer_q - 1'b1;
            state_d = (timer_q == '0) ? GAP : ASSERT;
        end else if (state_q == GAP) begin
            timer_d = (timer_q == '0) ? '0 : timer_q - 1'b1;
            state_d = (timer_q == '0) ? IDLE : GAP;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            timer_q <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
            gid_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
        end
    end
endmodule

// File: tb/tb_sync_tx_scheduler.sv
// tb_sync_tx_scheduler: random and directed stimulus against a cycle-count reference model with a word scoreboard
module tb_sync_tx_scheduler;
    localparam int N = 4, W = 8, H = 4, G = 4;
    logic clk = 0, rst = 1, ctrl_en = 0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   unsync_bus;
    logic           bus_enable, busy, xfer_done;
    logic [1:0]     grant_id;
    typedef struct packed {logic [1:0] id; logic [W-1:0] data;} word_t;
    word_t          q[$];
    int             checks = 0, errors = 0, busy_left = 0, rr = 0;
    logic [W-1:0]   held = '0;
    logic           prev_en = 0, mon_on = 0;
    always #5 clk = ~clk;
    sync_tx_scheduler #(.NUM_REQ(N), .BUS_WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_WIDTH(4)) dut (
        .CLK(clk), .RST(rst), .ctrl_en(ctrl_en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
        .grant_id(grant_id), .busy(busy), .xfer_done(xfer_done)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask
    // One source cycle: drive inputs, check against the model, then advance the model past the next edge
    task automatic cycle(input logic r, input logic e, input logic [N-1:0] v, input logic [N*W-1:0] d);
        int sel;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        rst = r; ctrl_en = e; req_valid = v; req_data = d;
        #1;
        chk("busy", busy, busy_left > 0);
        chk("bus_enable", bus_enable, busy_left > G);
        chk("xfer_done", xfer_done, busy_left == 1);
        exp_ready = '0;
        sel = -1;
        if (busy_left == 0 && e)
            for (int k = 0; k < N; k++)
                if (sel < 0 && v[(rr + k) % N]) sel = (rr + k) % N;
        if (sel >= 0) begin
            exp_ready[sel] = 1'b1;
            q.push_back('{id: 2'(sel), data: d[sel*W +: W]});
        end
        chk("req_ready", req_ready, exp_ready);
        if (r) begin
            busy_left = 0;
            rr = 0;
            held = '0;
        end else if (sel >= 0) begin
            busy_left = H + G;
            rr = (sel + 1) % N;
        end else if (busy_left > 0) busy_left--;
    endtask
    always @(negedge clk) if (mon_on) begin
        if (bus_enable && !prev_en) begin
            if (q.size() == 0) chk("unexpected_word", 1, 0);
            else begin
                word_t e;
                e = q.pop_front();
                chk("word_data", unsync_bus, e.data);
                chk("word_gid", grant_id, e.id);
                held = e.data;
            end
        end else chk("bus_stable", unsync_bus, held);
        prev_en = bus_enable;
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", bus_enable, 0);
        chk("rst_bus", unsync_bus, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_done", xfer_done, 0);
        mon_on = 1;
        cycle(0, 1, 4'b0100, 32'h00A5_0000);
        repeat (10) cycle(0, 1, 4'b0000, $urandom);
        repeat (40) cycle(0, 1, 4'b1111, 32'h1312_1110);
        repeat (10) cycle(0, 0, 4'b0000, 32'h0);
        repeat (9) cycle(0, 1, 4'b1000, $urandom);
        repeat (20) cycle(0, 1, 4'b1001, $urandom);
        repeat (3) cycle(0, 1, 4'b1111, $urandom);
        repeat (15) cycle(0, 0, 4'b1111, $urandom);
        repeat (10) cycle(0, 1, 4'b1111, $urandom);
        repeat (10) cycle(0, 0, 4'b0000, $urandom);
        cycle(0, 1, 4'b1111, $urandom);
        repeat (2) cycle(0, 0, 4'b1111, $urandom);
        cycle(1, 0, 4'b1111, $urandom);
        cycle(0, 0, 4'b1111, $urandom);
        chk("mid_rst_gid", grant_id, 0);
        chk("mid_rst_bus", unsync_bus, 0);
        cycle(0, 1, 4'b1111, $urandom);
        chk("post_rst_ready", req_ready, 4'b0001);
        repeat (600) cycle(0, $urandom_range(0, 7) != 0, N'($urandom), $urandom);
        repeat (300) cycle(0, 1'b1, N'($urandom_range(0, 15) & $urandom_range(0, 15)), $urandom);
        repeat (12) cycle(0, 0, 4'b0000, $urandom);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
